// File: rtl/serial_frame_rx_if.sv
// Parallel handshake and serial-line bundle for serial_frame_rx.
// The slave side is the receiver; the master side drives the line and consumes the frames.
interface serial_frame_rx_if #(
    parameter int WIDTH = 5
) ();
    logic             si;
    logic             bit_en;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_perr;
    logic             out_ferr;
    logic             overrun;
    logic             busy;

    modport slave (
        input  si, bit_en, out_ready,
        output out_data, out_valid, out_perr, out_ferr, overrun, busy
    );

    modport master (
        output si, bit_en, out_ready,
        input  out_data, out_valid, out_perr, out_ferr, overrun, busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Completed words are held on a valid/ready interface with parity, framing and sticky overrun status.
module serial_frame_rx #(
    parameter int WIDTH     = 5,
    parameter bit PARITY_EN = 1'b1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_frame_rx_if.slave      bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]   shift_r, shift_s;
    logic               par_r, par_s;
    logic               done_s;
    logic               perr_s;
    logic               ferr_s;
    logic [WIDTH-1:0]   data_r;
    logic               valid_r;
    logic               perr_r;
    logic               ferr_r;
    logic               ovr_r;

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // Next-state, shift and counter logic; everything advances only on a bit strobe.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        shift_s = shift_r;
        par_s   = par_r;
        done_s  = 1'b0;
        if (bus.bit_en) begin
            case (state_r)
                IDLE: begin
                    if (bus.si == 1'b0) begin
                        state_s = DATA;
                        cnt_s   = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                DATA: begin
                    if (MSB_FIRST) begin
                        shift_s = {shift_r[WIDTH-2:0], bus.si};
                    end else begin
                        shift_s = {bus.si, shift_r[WIDTH-1:1]};
                    end
                    cnt_s = cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        state_s = PARITY_EN ? PARITY : STOP;
                    end else begin
                        state_s = DATA;
                    end
                end
                PARITY: begin
                    par_s   = bus.si;
                    state_s = STOP;
                end
                STOP: begin
                    // A low stop bit returns to IDLE too; it is never treated as the next start bit.
                    done_s  = 1'b1;
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign perr_s = PARITY_EN ? (even_parity(shift_r) ^ par_r) : 1'b0;
    assign ferr_s = ~bus.si;

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            shift_r <= '0;
            par_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
            par_r   <= par_s;
        end
    end

    // Output holding register: load when empty or being drained, otherwise drop and flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= '0;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else if (done_s && (!valid_r || bus.out_ready)) begin
            data_r  <= shift_r;
            valid_r <= 1'b1;
            perr_r  <= perr_s;
            ferr_r  <= ferr_s;
        end else if (done_s) begin
            ovr_r   <= 1'b1;
        end else if (valid_r && bus.out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign bus.out_data  = data_r;
    assign bus.out_valid = valid_r;
    assign bus.out_perr  = perr_r;
    assign bus.out_ferr  = ferr_r;
    assign bus.overrun   = ovr_r;
    assign bus.busy      = (state_r != IDLE);
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with a scoreboard of expected delivered frames.
module tb_serial_frame_rx;
    localparam int WIDTH = 5;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             perr;
        logic             ferr;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    frame_t sb_q[$];

    serial_frame_rx_if #(.WIDTH(WIDTH)) bus ();

    serial_frame_rx #(.WIDTH(WIDTH), .PARITY_EN(1'b1), .MSB_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a handshake completes on the next rising edge, so compare at the falling edge before it.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                frame_t e;
                e = sb_q.pop_front();
                chk("sb_data", {27'd0, bus.out_data}, {27'd0, e.data});
                chk("sb_perr", {31'd0, bus.out_perr}, {31'd0, e.perr});
                chk("sb_ferr", {31'd0, bus.out_ferr}, {31'd0, e.ferr});
            end
        end
    end

    task automatic strobe(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            bus.bit_en = 1'b0;
            bus.si     = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.bit_en = 1'b1;
        bus.si     = b;
        @(posedge clk); #1;
        bus.bit_en = 1'b0;
        bus.si     = 1'b1;
    endtask

    task automatic send_body(input logic [WIDTH-1:0] d, input logic par, input logic stp, input int gap);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            strobe(d[i], gap);
        end
        strobe(par, gap);
        strobe(stp, gap);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] d, input logic par, input logic stp,
                              input int gap, input bit expect_delivery);
        frame_t e;
        e.data = d;
        e.perr = (^d) ^ par;
        e.ferr = ~stp;
        if (expect_delivery) begin
            sb_q.push_back(e);
        end
        strobe(1'b0, gap);
        send_body(d, par, stp, gap);
    endtask

    initial begin
        frame_t e;
        bus.si        = 1'b1;
        bus.bit_en    = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data",    {27'd0, bus.out_data}, 32'd0);
        chk("rst_busy",    {31'd0, bus.busy}, 32'd0);
        chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1 clean frame, single-cycle valid
        send_frame(5'b10110, 1'b1, 1'b1, 0, 1'b1);
        chk("t1_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_data",  {27'd0, bus.out_data}, 32'h16);
        chk("t1_busy",  {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        chk("t1_valid_drop", {31'd0, bus.out_valid}, 32'd0);

        // T2 parity error
        send_frame(5'b10110, 1'b0, 1'b1, 0, 1'b1);
        chk("t2_perr", {31'd0, bus.out_perr}, 32'd1);
        chk("t2_ferr", {31'd0, bus.out_ferr}, 32'd0);
        @(posedge clk); #1;

        // T3 framing error, then a fresh start bit
        send_frame(5'b10110, 1'b1, 1'b0, 0, 1'b1);
        chk("t3_ferr", {31'd0, bus.out_ferr}, 32'd1);
        chk("t3_idle", {31'd0, bus.busy}, 32'd0);
        e.data = 5'b11111; e.perr = 1'b0; e.ferr = 1'b0;
        sb_q.push_back(e);
        strobe(1'b0, 0);
        chk("t3_busy", {31'd0, bus.busy}, 32'd1);
        send_body(5'b11111, 1'b1, 1'b1, 0);
        chk("t3b_valid", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk); #1;

        // T4 backpressure and overrun
        bus.out_ready = 1'b0;
        send_frame(5'b10110, 1'b1, 1'b1, 0, 1'b1);
        send_frame(5'b01001, 1'b0, 1'b1, 0, 1'b0);
        chk("t4_valid",   {31'd0, bus.out_valid}, 32'd1);
        chk("t4_data",    {27'd0, bus.out_data}, 32'h16);
        chk("t4_overrun", {31'd0, bus.overrun}, 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_valid_drop",   {31'd0, bus.out_valid}, 32'd0);
        chk("t4_overrun_held", {31'd0, bus.overrun}, 32'd1);

        // T5 sparse strobes with glitches in between
        send_frame(5'b10110, 1'b1, 1'b1, 3, 1'b1);
        chk("t5_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t5_data",  {27'd0, bus.out_data}, 32'h16);
        @(posedge clk); #1;

        // T6 reset mid-frame, then a clean frame
        strobe(1'b0, 0);
        strobe(1'b1, 0);
        strobe(1'b0, 0);
        strobe(1'b1, 0);
        chk("t6_busy_pre", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_busy",    {31'd0, bus.busy}, 32'd0);
        chk("t6_valid",   {31'd0, bus.out_valid}, 32'd0);
        chk("t6_data",    {27'd0, bus.out_data}, 32'd0);
        chk("t6_overrun", {31'd0, bus.overrun}, 32'd0);
        send_frame(5'b00111, 1'b1, 1'b1, 0, 1'b1);
        chk("t6_rx_data", {27'd0, bus.out_data}, 32'h07);
        chk("t6_rx_perr", {31'd0, bus.out_perr}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
